// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared types and constants for the program-counter sequencer.
// Holds the FSM state encoding, the flow-control opcodes and default widths.
package pc_seq_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;
  localparam int BUS_W_DEF  = 24;

  localparam logic [7:0] OP_JUMP = 8'hF0;
  localparam logic [7:0] OP_JMPZ = 8'hF1;
  localparam logic [7:0] OP_END  = 8'hFF;

  // WAIT2/OPWAIT2 are only reachable when the 2-cycle ROM build is selected.
  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_WAIT2,
    ST_DECODE,
    ST_ISSUE,
    ST_OPFETCH,
    ST_OPWAIT,
    ST_OPWAIT2,
    ST_BRANCH,
    ST_HALT
  } state_e;

endpackage

// File: rtl/opcode_classify.sv
// opcode_classify: combinational flow-control opcode detector.
// Kept separate so the datapath decoder can reuse the same classification.
module opcode_classify
  import pc_seq_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] ir,
  output logic              is_jump,
  output logic              is_jmpz,
  output logic              is_end
);

  assign is_jump = (ir == DATA_W'(OP_JUMP));
  assign is_jmpz = (ir == DATA_W'(OP_JMPZ));
  assign is_end  = (ir == DATA_W'(OP_END));

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch/branch controller driving the program counter controls.
// Fetches a byte from the instruction ROM at the PC, classifies it, issues
// datapath instructions over valid/ready and resolves JUMP/JMPZ/END itself.
// Build option: define INSTR_ROM_2CYC_EN for a ROM with two cycles of read
// latency (adds WAIT2 and OPWAIT2 states).
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int BUS_W  = BUS_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] ins_address,
  output logic              rom_en,
  input  logic [DATA_W-1:0] rom_data,
  input  logic              z_flag,
  output logic [DATA_W-1:0] ir,
  output logic              ins_valid,
  input  logic              ins_ready,
  output logic              pc_enable,
  output logic              pc_load,
  output logic              pc_inc,
  output logic              pc_finish,
  output logic [BUS_W-1:0]  c_bus,
  output logic              busy
);

`ifdef INSTR_ROM_2CYC_EN
  localparam state_e IR_CAP_ST = ST_WAIT2;
  localparam state_e OP_CAP_ST = ST_OPWAIT2;
`else
  localparam state_e IR_CAP_ST = ST_WAIT;
  localparam state_e OP_CAP_ST = ST_OPWAIT;
`endif

  state_e             r_state;
  state_e             w_next;
  logic [DATA_W-1:0]  r_ir;
  logic [BUS_W-1:0]   r_c_bus;
  logic               w_is_jump;
  logic               w_is_jmpz;
  logic               w_is_end;
  logic               w_unused;

  // The PC value is informational only: the ROM is addressed by the PC itself.
  assign w_unused = ^ins_address;

  opcode_classify #(.DATA_W(DATA_W)) u_classify (
    .ir      (r_ir),
    .is_jump (w_is_jump),
    .is_jmpz (w_is_jmpz),
    .is_end  (w_is_end)
  );

  // State register; reset drops straight to IDLE so no PC pulse survives.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default assignment first so no path through the case infers a latch.
    w_next = r_state;
    case (r_state)
      ST_IDLE,
      ST_HALT:    if (start) w_next = ST_FETCH;
      ST_FETCH:   w_next = ST_WAIT;
`ifdef INSTR_ROM_2CYC_EN
      ST_WAIT:    w_next = ST_WAIT2;
      ST_WAIT2:   w_next = ST_DECODE;
`else
      ST_WAIT:    w_next = ST_DECODE;
`endif
      ST_DECODE: begin
        if (w_is_end)                   w_next = ST_HALT;
        else if (w_is_jump || w_is_jmpz) w_next = ST_OPFETCH;
        else                            w_next = ST_ISSUE;
      end
      ST_ISSUE:   if (ins_ready) w_next = ST_FETCH;
      ST_OPFETCH: w_next = ST_OPWAIT;
`ifdef INSTR_ROM_2CYC_EN
      ST_OPWAIT:  w_next = ST_OPWAIT2;
      ST_OPWAIT2: w_next = ST_BRANCH;
`else
      ST_OPWAIT:  w_next = ST_BRANCH;
`endif
      ST_BRANCH:  w_next = ST_FETCH;
      default:    w_next = ST_IDLE;
    endcase
  end

  // Output decode; pc_load and pc_inc are mutually exclusive by construction.
  always_comb begin
    rom_en    = 1'b0;
    ins_valid = 1'b0;
    pc_load   = 1'b0;
    pc_inc    = 1'b0;
    pc_finish = 1'b0;
    busy      = 1'b1;
    case (r_state)
      ST_IDLE: busy = 1'b0;
      ST_HALT: begin
        busy      = 1'b0;
        pc_finish = 1'b1;
      end
      ST_FETCH,
      ST_OPFETCH: rom_en = 1'b1;
      ST_DECODE: begin
        if (w_is_end)                    pc_finish = 1'b1;
        else if (w_is_jump || w_is_jmpz) pc_inc    = 1'b1;
      end
      ST_ISSUE: begin
        ins_valid = 1'b1;
        pc_inc    = ins_ready;
      end
      // Only JUMP and JMPZ reach BRANCH, so a non-JUMP here is a JMPZ.
      ST_BRANCH: begin
        if (w_is_jump || z_flag) pc_load = 1'b1;
        else                     pc_inc  = 1'b1;
      end
      default: ;
    endcase
  end

  assign pc_enable = busy;

  // Instruction and jump-target capture from the ROM read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ir    <= '0;
      r_c_bus <= '0;
    end else begin
      if (r_state == IR_CAP_ST) r_ir    <= rom_data;
      if (r_state == OP_CAP_ST) r_c_bus <= BUS_W'(rom_data);
    end
  end

  assign ir    = r_ir;
  assign c_bus = r_c_bus;

endmodule
